// File: rtl/c7bbiu_lsu_resp.sv
// LSU-facing responder in the BIU: accepts one load or store at a time from the LSU,
// runs it as a doubleword transaction on the mem_* bus and returns data/completion.
module c7bbiu_lsu_resp #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        lsu_biu_rd_req_ls2,
    input  logic [31:0] lsu_biu_rd_addr_ls2,
    output logic        biu_lsu_rd_ack_ls2,
    output logic        biu_lsu_data_valid_ls3,
    output logic [63:0] biu_lsu_data_ls3,
    output logic        biu_lsu_rd_err_ls3,

    input  logic        lsu_biu_wr_req_ls2,
    input  logic [31:0] lsu_biu_wr_addr_ls2,
    input  logic [63:0] lsu_biu_wr_data_ls2,
    input  logic [7:0]  lsu_biu_wr_strb_ls2,
    output logic        biu_lsu_wr_ack_ls2,
    output logic        biu_lsu_wr_done_ls3,
    output logic        biu_lsu_wr_err_ls3,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] tmo_cnt_q;
    logic        tmo_hit;
    logic        take_rd;
    logic        take_wr;
    logic        resp_now;
    logic        resp_err;
    logic [63:0] resp_data;

    // The counter shows the number of cycles already spent in ISSUE/WAIT, so the
    // last permitted cycle is TIMEOUT_CYCLES-1; an rvalid in that cycle still wins.
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        take_rd   = 1'b0;
        take_wr   = 1'b0;
        resp_now  = 1'b0;
        resp_err  = 1'b0;
        resp_data = 64'd0;
        case (state_q)
            IDLE: begin
                if (lsu_biu_rd_req_ls2) begin
                    take_rd = 1'b1;
                    state_d = ISSUE;
                end else if (lsu_biu_wr_req_ls2) begin
                    take_wr = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt && mem_rvalid) begin
                    resp_now  = 1'b1;
                    resp_err  = mem_err;
                    resp_data = mem_rdata;
                    state_d   = RESP;
                end else if (tmo_hit) begin
                    resp_now = 1'b1;
                    resp_err = 1'b1;
                    state_d  = RESP;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    resp_now  = 1'b1;
                    resp_err  = mem_err;
                    resp_data = mem_rdata;
                    state_d   = RESP;
                end else if (tmo_hit) begin
                    resp_now = 1'b1;
                    resp_err = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tmo_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ISSUE || state_q == WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end else begin
                tmo_cnt_q <= 16'd0;
            end
        end
    end

    // Every LSU and bus output is a flop, so LSU inputs never reach LSU outputs combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            biu_lsu_rd_ack_ls2     <= 1'b0;
            biu_lsu_wr_ack_ls2     <= 1'b0;
            biu_lsu_data_valid_ls3 <= 1'b0;
            biu_lsu_data_ls3       <= 64'd0;
            biu_lsu_rd_err_ls3     <= 1'b0;
            biu_lsu_wr_done_ls3    <= 1'b0;
            biu_lsu_wr_err_ls3     <= 1'b0;
            mem_req                <= 1'b0;
            mem_we                 <= 1'b0;
            mem_addr               <= 32'd0;
            mem_wdata              <= 64'd0;
            mem_wstrb              <= 8'd0;
        end else begin
            biu_lsu_rd_ack_ls2     <= take_rd;
            biu_lsu_wr_ack_ls2     <= take_wr;
            biu_lsu_data_valid_ls3 <= resp_now & ~mem_we;
            biu_lsu_rd_err_ls3     <= resp_now & ~mem_we & resp_err;
            biu_lsu_wr_done_ls3    <= resp_now & mem_we;
            biu_lsu_wr_err_ls3     <= resp_now & mem_we & resp_err;
            if (resp_now && !mem_we) begin
                biu_lsu_data_ls3 <= resp_err ? 64'd0 : resp_data;
            end

            if (take_rd) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= lsu_biu_rd_addr_ls2 & ~32'h7;
                mem_wdata <= 64'd0;
                mem_wstrb <= 8'd0;
            end else if (take_wr) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= lsu_biu_wr_addr_ls2 & ~32'h7;
                mem_wdata <= lsu_biu_wr_data_ls2;
                mem_wstrb <= lsu_biu_wr_strb_ls2;
            end else if (state_q == ISSUE && state_d != ISSUE) begin
                mem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_c7bbiu_lsu_resp.sv
// Bench for c7bbiu_lsu_resp: directed scenarios plus random loads/stores, with a
// transaction-level model predicting ack, bus fields, response cycle, data and error.
module tb_c7bbiu_lsu_resp;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_biu_rd_req_ls2;
    logic [31:0] lsu_biu_rd_addr_ls2;
    logic        biu_lsu_rd_ack_ls2;
    logic        biu_lsu_data_valid_ls3;
    logic [63:0] biu_lsu_data_ls3;
    logic        biu_lsu_rd_err_ls3;
    logic        lsu_biu_wr_req_ls2;
    logic [31:0] lsu_biu_wr_addr_ls2;
    logic [63:0] lsu_biu_wr_data_ls2;
    logic [7:0]  lsu_biu_wr_strb_ls2;
    logic        biu_lsu_wr_ack_ls2;
    logic        biu_lsu_wr_done_ls3;
    logic        biu_lsu_wr_err_ls3;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    c7bbiu_lsu_resp #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .lsu_biu_rd_req_ls2     (lsu_biu_rd_req_ls2),
        .lsu_biu_rd_addr_ls2    (lsu_biu_rd_addr_ls2),
        .biu_lsu_rd_ack_ls2     (biu_lsu_rd_ack_ls2),
        .biu_lsu_data_valid_ls3 (biu_lsu_data_valid_ls3),
        .biu_lsu_data_ls3       (biu_lsu_data_ls3),
        .biu_lsu_rd_err_ls3     (biu_lsu_rd_err_ls3),
        .lsu_biu_wr_req_ls2     (lsu_biu_wr_req_ls2),
        .lsu_biu_wr_addr_ls2    (lsu_biu_wr_addr_ls2),
        .lsu_biu_wr_data_ls2    (lsu_biu_wr_data_ls2),
        .lsu_biu_wr_strb_ls2    (lsu_biu_wr_strb_ls2),
        .biu_lsu_wr_ack_ls2     (biu_lsu_wr_ack_ls2),
        .biu_lsu_wr_done_ls3    (biu_lsu_wr_done_ls3),
        .biu_lsu_wr_err_ls3     (biu_lsu_wr_err_ls3),
        .mem_req                (mem_req),
        .mem_we                 (mem_we),
        .mem_addr               (mem_addr),
        .mem_wdata              (mem_wdata),
        .mem_wstrb              (mem_wstrb),
        .mem_gnt                (mem_gnt),
        .mem_rvalid             (mem_rvalid),
        .mem_rdata              (mem_rdata),
        .mem_err                (mem_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic memQuiet();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = 64'd0;
    endtask

    function automatic logic anyOutput();
        return |{biu_lsu_rd_ack_ls2, biu_lsu_data_valid_ls3, biu_lsu_data_ls3, biu_lsu_rd_err_ls3,
                 biu_lsu_wr_ack_ls2, biu_lsu_wr_done_ls3, biu_lsu_wr_err_ls3,
                 mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb};
    endfunction

    // One transaction from an IDLE negedge; the memory answers gntDelay cycles after
    // ISSUE entry and rvDelay cycles after the grant, or never when noResp is set.
    task automatic applyStimulus(input bit isRead, input logic [31:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] strb, input int gntDelay, input int rvDelay,
                                 input bit noResp, input bit memErrIn, input logic [63:0] rdataIn);
        logic        expErr;
        logic [63:0] expData;
        int          expCycle;
        int          pulseAt;
        logic        gotRead;
        logic        gotWrite;
        logic        gotErr;
        logic [63:0] gotData;

        expErr   = noResp ? 1'b1 : memErrIn;
        expData  = (isRead && !expErr) ? rdataIn : 64'd0;
        expCycle = noResp ? TMO : gntDelay + rvDelay + 1;
        pulseAt  = -1;
        gotRead  = 1'b0;
        gotWrite = 1'b0;
        gotErr   = 1'b0;
        gotData  = 64'd0;

        if (isRead) begin
            lsu_biu_rd_req_ls2  = 1'b1;
            lsu_biu_rd_addr_ls2 = addr;
        end else begin
            lsu_biu_wr_req_ls2  = 1'b1;
            lsu_biu_wr_addr_ls2 = addr;
            lsu_biu_wr_data_ls2 = wdata;
            lsu_biu_wr_strb_ls2 = strb;
        end
        @(negedge clk);
        checkOutput(isRead ? "rd_ack" : "wr_ack", isRead ? biu_lsu_rd_ack_ls2 : biu_lsu_wr_ack_ls2, 1);
        checkOutput("other_ack", isRead ? biu_lsu_wr_ack_ls2 : biu_lsu_rd_ack_ls2, 0);
        checkOutput("mem_req_on", mem_req, 1);
        checkOutput("mem_we", mem_we, isRead ? 0 : 1);
        checkOutput("mem_addr", mem_addr, addr - (addr % 8));
        checkOutput("mem_wdata", mem_wdata, isRead ? 64'd0 : wdata);
        checkOutput("mem_wstrb", mem_wstrb, isRead ? 8'd0 : strb);
        if (isRead) lsu_biu_rd_req_ls2 = 1'b0;
        else        lsu_biu_wr_req_ls2 = 1'b0;

        for (int j = 0; j <= TMO + 3; j++) begin
            if (j > 0) begin
                checkOutput("stray_ack", {biu_lsu_rd_ack_ls2, biu_lsu_wr_ack_ls2}, 0);
                if (biu_lsu_data_valid_ls3 || biu_lsu_wr_done_ls3) begin
                    pulseAt  = j;
                    gotRead  = biu_lsu_data_valid_ls3;
                    gotWrite = biu_lsu_wr_done_ls3;
                    gotErr   = biu_lsu_data_valid_ls3 ? biu_lsu_rd_err_ls3 : biu_lsu_wr_err_ls3;
                    gotData  = biu_lsu_data_ls3;
                    break;
                end
            end
            mem_gnt    = (j == gntDelay);
            mem_rvalid = !noResp && (j == gntDelay + rvDelay);
            mem_err    = mem_rvalid ? memErrIn : 1'b0;
            mem_rdata  = mem_rvalid ? rdataIn : {$urandom, $urandom};
            if (j < gntDelay && $urandom_range(0, 3) == 0) begin
                mem_rvalid = 1'b1;
                mem_err    = 1'b1;
            end
            @(negedge clk);
        end

        checkOutput("resp_cycle", pulseAt, expCycle);
        checkOutput("resp_kind", {gotRead, gotWrite}, isRead ? 2'b10 : 2'b01);
        checkOutput("resp_err", gotErr, expErr);
        if (isRead) checkOutput("rd_data", gotData, expData);
        checkOutput("mem_req_off", mem_req, 0);

        mem_gnt    = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_err    = 1'b1;
        mem_rdata  = {$urandom, $urandom};
        @(negedge clk);
        memQuiet();
        checkOutput("no_extra", {biu_lsu_data_valid_ls3, biu_lsu_wr_done_ls3}, 0);
    endtask

    initial begin
        logic [31:0] wa;
        logic [63:0] wd;
        logic [7:0]  ws;

        reset               = 1'b1;
        lsu_biu_rd_req_ls2  = 1'b0;
        lsu_biu_rd_addr_ls2 = 32'd0;
        lsu_biu_wr_req_ls2  = 1'b0;
        lsu_biu_wr_addr_ls2 = 32'd0;
        lsu_biu_wr_data_ls2 = 64'd0;
        lsu_biu_wr_strb_ls2 = 8'd0;
        memQuiet();
        repeat (2) @(negedge clk);
        checkOutput("reset_state", anyOutput(), 0);
        reset = 1'b0;
        @(negedge clk);

        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        memQuiet();
        checkOutput("idle_spurious", {biu_lsu_data_valid_ls3, biu_lsu_wr_done_ls3}, 0);

        applyStimulus(1, 32'h0000_1004, 64'd0, 8'd0, 0, 1, 0, 0, 64'h1234_5678_9ABC_DEF0);
        applyStimulus(0, 32'h0000_2002, 64'h0000_0000_00AA_0000, 8'h04, 0, 1, 0, 0, 64'd0);

        // Both requests together: the read goes first while the write stays held.
        lsu_biu_wr_req_ls2  = 1'b1;
        lsu_biu_wr_addr_ls2 = 32'h0000_300C;
        lsu_biu_wr_data_ls2 = 64'h0102_0304_0506_0708;
        lsu_biu_wr_strb_ls2 = 8'hF0;
        applyStimulus(1, 32'h0000_3010, 64'd0, 8'd0, 1, 1, 0, 0, 64'hCAFE_F00D_1111_2222);
        applyStimulus(0, 32'h0000_300C, 64'h0102_0304_0506_0708, 8'hF0, 0, 0, 0, 0, 64'd0);

        applyStimulus(1, 32'h0000_4000, 64'd0, 8'd0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(0, 32'h0000_4100, 64'h55, 8'h01, 2, 0, 0, 1, 64'd0);

        applyStimulus(1, 32'h0000_5000, 64'd0, 8'd0, 0, 0, 1, 0, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        @(negedge clk);
        memQuiet();
        checkOutput("late_rvalid", biu_lsu_data_valid_ls3, 0);
        applyStimulus(1, 32'h0000_5008, 64'd0, 8'd0, 0, 1, 0, 0, 64'h7777_8888_9999_AAAA);
        applyStimulus(0, 32'h0000_5010, 64'hAB, 8'h01, 3, 2, 1, 0, 64'd0);

        // Reset while the read waits for its response; that read must vanish silently.
        lsu_biu_rd_req_ls2  = 1'b1;
        lsu_biu_rd_addr_ls2 = 32'h0000_6000;
        @(negedge clk);
        lsu_biu_rd_req_ls2 = 1'b0;
        mem_gnt            = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_wait", anyOutput(), 0);
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h6666_6666_6666_6666;
        @(negedge clk);
        memQuiet();
        for (int k = 0; k < 3; k++) begin
            checkOutput("post_reset_quiet", {biu_lsu_data_valid_ls3, mem_req}, 0);
            @(negedge clk);
        end
        applyStimulus(1, 32'h0000_6008, 64'd0, 8'd0, 0, 1, 0, 0, 64'h0123_4567_89AB_CDEF);

        for (int n = 0; n < 40; n++) begin
            wa = $urandom;
            wd = {$urandom, $urandom};
            ws = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                lsu_biu_wr_req_ls2  = 1'b1;
                lsu_biu_wr_addr_ls2 = wa;
                lsu_biu_wr_data_ls2 = wd;
                lsu_biu_wr_strb_ls2 = ws;
                applyStimulus(1, $urandom, 64'd0, 8'd0, $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, {$urandom, $urandom});
                applyStimulus(0, wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 64'd0);
            end else begin
                applyStimulus($urandom_range(0, 1) == 1, wa, wd, ws, $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                              $urandom_range(0, 5) == 0, {$urandom, $urandom});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
